// File: rtl/fpu_agent_arbiter.sv
// Round-robin arbiter sharing one FPU agent channel among NUM_REQS issue slices.
// Granted ops get a pending-table tag; FPU responses are routed back to their owner by that tag.
module fpu_agent_arbiter #(
   parameter int NUM_REQS    = 4,
   parameter int DATAW       = 256,
   parameter int RSP_DATAW   = 128,
   parameter int MAX_PENDING = 8,
   parameter int TAG_W       = $clog2(MAX_PENDING)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   output logic [NUM_REQS-1:0]       req_ready,
   output logic                      fpu_req_valid,
   output logic [DATAW-1:0]          fpu_req_data,
   output logic [TAG_W-1:0]          fpu_req_tag,
   input  logic                      fpu_req_ready,
   input  logic                      fpu_rsp_valid,
   input  logic [TAG_W-1:0]          fpu_rsp_tag,
   input  logic [RSP_DATAW-1:0]      fpu_rsp_data,
   output logic                      fpu_rsp_ready,
   output logic [NUM_REQS-1:0]       rsp_valid,
   output logic [RSP_DATAW-1:0]      rsp_data,
   input  logic [NUM_REQS-1:0]       rsp_ready,
   output logic [TAG_W:0]            pending_count
);

   localparam int REQ_W = $clog2(NUM_REQS);

   logic [MAX_PENDING-1:0] busy;
   logic [REQ_W-1:0]       owner [MAX_PENDING];
   logic [REQ_W-1:0]       rr_ptr;
   logic                   drain_window;

   logic             can_load;
   logic             has_free;
   logic             grant_found;
   logic             grant_fire;
   logic [REQ_W-1:0] grant_idx;
   logic [TAG_W-1:0] free_tag;
   logic [REQ_W-1:0] rsp_owner;
   logic             rsp_busy;
   logic             retire;

   assign can_load = !fpu_req_valid || fpu_req_ready;
   assign has_free = pending_count < (TAG_W+1)'(MAX_PENDING);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin : free_tag_search
      free_tag = '0;
      for (int i = MAX_PENDING - 1; i >= 0; i--) begin
         if (!busy[TAG_W'(i)]) free_tag = TAG_W'(i);
      end
   end

   always_comb begin : grant_search
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQS) idx = idx - NUM_REQS;
         if (!grant_found && req_valid[REQ_W'(idx)]) begin
            grant_found = 1'b1;
            grant_idx   = REQ_W'(idx);
         end
      end
   end

   assign grant_fire = can_load && has_free && grant_found;

   always_comb begin
      req_ready = '0;
      if (grant_fire) req_ready[grant_idx] = 1'b1;
   end

   // Response routing is purely combinational; a tag that is not busy is acknowledged and dropped.
   assign rsp_owner     = owner[fpu_rsp_tag];
   assign rsp_busy      = busy[fpu_rsp_tag];
   assign rsp_data      = fpu_rsp_data;
   assign fpu_rsp_ready = rsp_busy ? rsp_ready[rsp_owner] : 1'b1;
   assign retire        = fpu_rsp_valid && fpu_rsp_ready && rsp_busy;

   always_comb begin
      rsp_valid = '0;
      if (fpu_rsp_valid && rsp_busy) rsp_valid[rsp_owner] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         fpu_req_valid <= 1'b0;
         busy          <= '0;
         pending_count <= '0;
         rr_ptr        <= '0;
         drain_window  <= 1'b1;
      end else begin
         if (grant_fire)         fpu_req_valid <= 1'b1;
         else if (fpu_req_ready) fpu_req_valid <= 1'b0;

         if (grant_fire) begin
            rr_ptr       <= (grant_idx == REQ_W'(NUM_REQS - 1)) ? '0 : grant_idx + REQ_W'(1);
            drain_window <= 1'b0;
         end

         // A retiring tag is busy and the granted tag is free, so the two never collide.
         if (retire)     busy[fpu_rsp_tag] <= 1'b0;
         if (grant_fire) busy[free_tag]    <= 1'b1;

         case ({grant_fire, retire})
            2'b10:   pending_count <= pending_count + (TAG_W+1)'(1);
            2'b01:   pending_count <= pending_count - (TAG_W+1)'(1);
            default: pending_count <= pending_count;
         endcase
      end
   end

   // NOTE: payload, tag and owner table are left unreset; busy and fpu_req_valid qualify them.
   always_ff @(posedge clk) begin
      if (grant_fire) begin
         fpu_req_data    <= req_data[int'(grant_idx)*DATAW +: DATAW];
         fpu_req_tag     <= free_tag;
         owner[free_tag] <= grant_idx;
      end
   end

   // Responses to ops discarded by reset may still trickle in until new work is issued.
   stale_rsp_chk : assert property (@(posedge clk) disable iff (reset)
      (fpu_rsp_valid && !rsp_busy) |-> drain_window)
      else $error("fpu_agent_arbiter: stale response tag %0d outside post-reset window", fpu_rsp_tag);

endmodule

// File: tb/tb_fpu_agent_arbiter.sv
// Self-checking bench for fpu_agent_arbiter: a behavioural model predicts grants and routing,
// and scoreboard queues hold the expected FPU requests and routed responses.
module tb_fpu_agent_arbiter;

   localparam int NUM_REQS    = 4;
   localparam int DATAW       = 256;
   localparam int RSP_DATAW   = 128;
   localparam int MAX_PENDING = 8;
   localparam int TAG_W       = 3;

   logic                      clk;
   logic                      reset;
   logic [NUM_REQS-1:0]       req_valid;
   logic [NUM_REQS*DATAW-1:0] req_data;
   logic [NUM_REQS-1:0]       req_ready;
   logic                      fpu_req_valid;
   logic [DATAW-1:0]          fpu_req_data;
   logic [TAG_W-1:0]          fpu_req_tag;
   logic                      fpu_req_ready;
   logic                      fpu_rsp_valid;
   logic [TAG_W-1:0]          fpu_rsp_tag;
   logic [RSP_DATAW-1:0]      fpu_rsp_data;
   logic                      fpu_rsp_ready;
   logic [NUM_REQS-1:0]       rsp_valid;
   logic [RSP_DATAW-1:0]      rsp_data;
   logic [NUM_REQS-1:0]       rsp_ready;
   logic [TAG_W:0]            pending_count;

   logic [DATAW-1:0] pay [NUM_REQS];

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_pay
      assign req_data[g*DATAW +: DATAW] = pay[g];
   end

   fpu_agent_arbiter #(
      .NUM_REQS(NUM_REQS), .DATAW(DATAW), .RSP_DATAW(RSP_DATAW),
      .MAX_PENDING(MAX_PENDING), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fpu_req_valid(fpu_req_valid), .fpu_req_data(fpu_req_data),
      .fpu_req_tag(fpu_req_tag), .fpu_req_ready(fpu_req_ready),
      .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_tag(fpu_rsp_tag),
      .fpu_rsp_data(fpu_rsp_data), .fpu_rsp_ready(fpu_rsp_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .pending_count(pending_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [DATAW-1:0] data;
      logic [TAG_W-1:0] tag;
   } req_exp_t;

   typedef struct packed {
      logic [1:0]           who;
      logic [RSP_DATAW-1:0] data;
   } rsp_exp_t;

   typedef struct {
      int tag;
      int at;
   } iss_t;

   req_exp_t req_q[$];
   rsp_exp_t rsp_q[$];
   iss_t     iss_q[$];

   bit m_busy [MAX_PENDING];
   int m_owner [MAX_PENDING];
   int m_pending;
   int m_rr;
   bit m_out_valid;
   int cyc;
   bit auto_rsp;
   int rsp_delay;

   function automatic logic [DATAW-1:0] rnd_wide();
      logic [DATAW-1:0] r;
      r = '0;
      for (int i = 0; i < DATAW / 32; i++) r = (r << 32) | DATAW'($urandom());
      return r;
   endfunction

   task automatic new_payloads();
      for (int i = 0; i < NUM_REQS; i++) pay[i] = rnd_wide();
   endtask

   task automatic model_clear();
      for (int t = 0; t < MAX_PENDING; t++) begin
         m_busy[t]  = 1'b0;
         m_owner[t] = 0;
      end
      m_pending   = 0;
      m_rr        = 0;
      m_out_valid = 1'b0;
      req_q.delete();
      rsp_q.delete();
      iss_q.delete();
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      req_valid     = '0;
      fpu_rsp_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   // One clock: evaluate the model against the DUT mid-cycle, then advance to just past the edge.
   task automatic cycle();
      int g, ft, rt, o, hit;
      logic [NUM_REQS-1:0] exp_ready;
      logic [NUM_REQS-1:0] exp_rv;
      logic                exp_fr;
      req_exp_t qe;
      rsp_exp_t re;
      iss_t     ie;
      if (auto_rsp) begin
         if (iss_q.size() > 0 && iss_q[0].at + rsp_delay <= cyc) begin
            fpu_rsp_valid = 1'b1;
            fpu_rsp_tag   = TAG_W'(iss_q[0].tag);
            fpu_rsp_data  = RSP_DATAW'(rnd_wide());
         end else begin
            fpu_rsp_valid = 1'b0;
         end
      end
      #2;
      g         = -1;
      exp_ready = '0;
      if ((!m_out_valid || fpu_req_ready) && m_pending < MAX_PENDING) begin
         for (int k = 0; k < NUM_REQS; k++) begin
            int c;
            c = (m_rr + k) % NUM_REQS;
            if (g < 0 && req_valid[c]) g = c;
         end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", 256'(req_ready), 256'(exp_ready));
      check("pending_count", 256'(pending_count), 256'(m_pending));

      rt     = -1;
      exp_rv = '0;
      exp_fr = 1'b1;
      if (fpu_rsp_valid && m_busy[fpu_rsp_tag]) begin
         o         = m_owner[fpu_rsp_tag];
         exp_rv[o] = 1'b1;
         exp_fr    = rsp_ready[o];
         if (rsp_ready[o]) begin
            rt      = int'(fpu_rsp_tag);
            re.who  = 2'(o);
            re.data = fpu_rsp_data;
            rsp_q.push_back(re);
         end
      end
      check("rsp_valid", 256'(rsp_valid), 256'(exp_rv));
      check("fpu_rsp_ready", 256'(fpu_rsp_ready), 256'(exp_fr));

      if (g >= 0) begin
         ft = 0;
         for (int t = MAX_PENDING - 1; t >= 0; t--) if (!m_busy[t]) ft = t;
         qe.data = pay[g];
         qe.tag  = TAG_W'(ft);
         req_q.push_back(qe);
         ie.tag = ft;
         ie.at  = cyc;
         iss_q.push_back(ie);
         m_busy[ft]  = 1'b1;
         m_owner[ft] = g;
         m_rr        = (g + 1) % NUM_REQS;
         m_pending++;
      end
      if (rt >= 0) begin
         m_busy[rt] = 1'b0;
         m_pending--;
         hit = -1;
         for (int i = 0; i < iss_q.size(); i++) if (hit < 0 && iss_q[i].tag == rt) hit = i;
         if (hit >= 0) iss_q.delete(hit);
      end
      m_out_valid = (g >= 0) ? 1'b1 : (fpu_req_ready ? 1'b0 : m_out_valid);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input int delay);
      int n;
      req_valid = '0;
      rsp_ready = '1;
      auto_rsp  = 1'b1;
      rsp_delay = delay;
      n         = 0;
      while (iss_q.size() > 0 && n < 40) begin
         cycle();
         n++;
      end
      auto_rsp      = 1'b0;
      fpu_rsp_valid = 1'b0;
      cycle();
      check("drain_pending", 256'(pending_count), 256'(0));
   endtask

   // Scoreboard consumers: FPU-side request handshakes and requester-side response handshakes.
   always @(negedge clk) begin
      req_exp_t qe;
      rsp_exp_t re;
      if (!reset) begin
         if (fpu_req_valid && fpu_req_ready) begin
            check("req_q_level", 256'(req_q.size() > 0), 256'(1));
            if (req_q.size() > 0) begin
               qe = req_q.pop_front();
               check("fpu_req_data", fpu_req_data, qe.data);
               check("fpu_req_tag", 256'(fpu_req_tag), 256'(qe.tag));
            end
         end
         for (int o = 0; o < NUM_REQS; o++) begin
            if (rsp_valid[o] && rsp_ready[o]) begin
               check("rsp_q_level", 256'(rsp_q.size() > 0), 256'(1));
               if (rsp_q.size() > 0) begin
                  re = rsp_q.pop_front();
                  check("rsp_who", 256'(o), 256'(re.who));
                  check("rsp_data", 256'(rsp_data), 256'(re.data));
               end
            end
         end
      end
   end

   initial begin
      reset         = 1'b1;
      req_valid     = '0;
      fpu_req_ready = 1'b1;
      fpu_rsp_valid = 1'b0;
      fpu_rsp_tag   = '0;
      fpu_rsp_data  = '0;
      rsp_ready     = '1;
      auto_rsp      = 1'b0;
      rsp_delay     = 0;
      cyc           = 0;
      new_payloads();
      do_reset();

      check("reset_fpu_req_valid", 256'(fpu_req_valid), 256'(0));
      check("reset_pending", 256'(pending_count), 256'(0));
      check("reset_req_ready", 256'(req_ready), 256'(0));

      // All requesters busy, FPU always ready: strict rotation until the tag table fills.
      req_valid = '1;
      for (int k = 0; k < 10; k++) begin
         new_payloads();
         #1;
         check("t1_grant", 256'(req_ready), (k < 8) ? 256'(4'b0001 << (k % 4)) : 256'(0));
         cycle();
         if (k < 8) check("t1_tag", 256'(fpu_req_tag), 256'(k));
      end
      check("t1_pending_full", 256'(pending_count), 256'(8));
      drain(0);

      // Single requester with responses coming back three cycles after grant.
      req_valid = 4'b0100;
      auto_rsp  = 1'b1;
      rsp_delay = 3;
      for (int k = 0; k < 12; k++) begin
         new_payloads();
         #1;
         check("t2_ready", 256'(req_ready), 256'(4'b0100));
         cycle();
      end
      drain(3);

      // FPU stall with one op held in the output register.
      req_valid = 4'b0010;
      new_payloads();
      cycle();
      fpu_req_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         new_payloads();
         #1;
         check("t3_stall_ready", 256'(req_ready), 256'(0));
         check("t3_stall_valid", 256'(fpu_req_valid), 256'(1));
         cycle();
      end
      fpu_req_ready = 1'b1;
      new_payloads();
      #1;
      check("t3_resume_ready", 256'(req_ready), 256'(4'b0010));
      cycle();
      drain(0);

      // Out-of-order responses routed back to their owners.
      do_reset();
      req_valid = 4'b1000;
      new_payloads();
      cycle();
      check("t4_tag_req3", 256'(fpu_req_tag), 256'(0));
      req_valid = 4'b0001;
      cycle();
      check("t4_tag_req0", 256'(fpu_req_tag), 256'(1));
      req_valid = '0;
      cycle();
      check("t4_pending2", 256'(pending_count), 256'(2));
      fpu_rsp_valid = 1'b1;
      fpu_rsp_tag   = 3'd1;
      fpu_rsp_data  = RSP_DATAW'(rnd_wide());
      #1;
      check("t4_rsp_req0", 256'(rsp_valid), 256'(4'b0001));
      cycle();
      check("t4_pending1", 256'(pending_count), 256'(1));
      fpu_rsp_tag  = 3'd0;
      fpu_rsp_data = RSP_DATAW'(rnd_wide());
      #1;
      check("t4_rsp_req3", 256'(rsp_valid), 256'(4'b1000));
      cycle();
      fpu_rsp_valid = 1'b0;
      check("t4_pending0", 256'(pending_count), 256'(0));

      // Full table: a retiring tag frees its slot only from the next cycle on.
      do_reset();
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         new_payloads();
         cycle();
      end
      fpu_rsp_valid = 1'b1;
      fpu_rsp_tag   = 3'd5;
      fpu_rsp_data  = RSP_DATAW'(rnd_wide());
      new_payloads();
      #1;
      check("t5_full_ready", 256'(req_ready), 256'(0));
      check("t5_rsp_owner", 256'(rsp_valid), 256'(4'b0010));
      cycle();
      fpu_rsp_valid = 1'b0;
      new_payloads();
      #1;
      check("t5_regrant", 256'(req_ready), 256'(4'b0001));
      cycle();
      check("t5_reused_tag", 256'(fpu_req_tag), 256'(5));
      check("t5_req_valid", 256'(fpu_req_valid), 256'(1));
      check("t5_pending", 256'(pending_count), 256'(8));

      // Reset with work in flight; a late response afterwards is dropped.
      do_reset();
      req_valid = '1;
      for (int k = 0; k < 4; k++) begin
         new_payloads();
         cycle();
      end
      check("t6_pending4", 256'(pending_count), 256'(4));
      check("t6_valid_before", 256'(fpu_req_valid), 256'(1));
      do_reset();
      check("t6_valid_after", 256'(fpu_req_valid), 256'(0));
      check("t6_pending_after", 256'(pending_count), 256'(0));
      fpu_rsp_valid = 1'b1;
      fpu_rsp_tag   = 3'd2;
      fpu_rsp_data  = RSP_DATAW'(rnd_wide());
      #1;
      check("t6_stale_rsp_valid", 256'(rsp_valid), 256'(0));
      check("t6_stale_rsp_ready", 256'(fpu_rsp_ready), 256'(1));
      cycle();
      fpu_rsp_valid = 1'b0;
      cycle();
      check("t6_pending_final", 256'(pending_count), 256'(0));

      check("req_q_empty", 256'(req_q.size()), 256'(0));
      check("rsp_q_empty", 256'(rsp_q.size()), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_agent_arbiter.md
Name: fpu_agent_arbiter

Overview:
- Shares one FPU agent request/response channel among NUM_REQS issue requesters (one per issue slice).
- Arbitrates requests round-robin and tags each granted request with a pending-table index.
- Demultiplexes FPU responses back to the originating requester by tag.
- Bounds in-flight operations to MAX_PENDING and sits between the issue slices and the FPU unit.

Parameters:
- NUM_REQS, 4, number of requesters (≥2).
- DATAW, 256, packed request payload width (uuid, wid, tmask, PC, op_type, fmt, frm, rs1/rs2/rs3 data, rd).
- RSP_DATAW, 128, packed response payload width.
- MAX_PENDING, 8, in-flight operation limit; power of 2.
- TAG_W, log2(MAX_PENDING), tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_data  in  NUM_REQS*DATAW  per-requester payload; slice i = requester i.
- req_ready  out  NUM_REQS  per-requester accept.
- fpu_req_valid  out  1  registered request to FPU.
- fpu_req_data  out  DATAW  registered payload.
- fpu_req_tag  out  TAG_W  pending-table index for this op.
- fpu_req_ready  in  1  FPU accept.
- fpu_rsp_valid  in  1  FPU response valid.
- fpu_rsp_tag  in  TAG_W  tag of the completing op.
- fpu_rsp_data  in  RSP_DATAW  response payload.
- fpu_rsp_ready  out  1  response accept.
- rsp_valid  out  NUM_REQS  per-requester response valid.
- rsp_data  out  RSP_DATAW  response payload, broadcast to all requesters.
- rsp_ready  in  NUM_REQS  per-requester response accept.
- pending_count  out  TAG_W+1  number of busy tags.

Behaviour:
- **Reset (clk edge with reset=1):**
  - fpu_req_valid=0; all busy bits=0; pending_count=0; rr_ptr=0.
  - Owner table contents don't-care.
  - Combinational outputs follow from this cleared state.
- **Output stage:** single register (fpu_req_valid/data/tag). `can_load = !fpu_req_valid || fpu_req_ready`.
- **Free tag:** `free_tag` = lowest-index slot with busy=0. `has_free = (pending_count < MAX_PENDING)`.
- **Grant:**
  - When `can_load && has_free`, grant the first asserted req_valid searching from rr_ptr upward, wrapping NUM_REQS-1 → 0.
  - req_ready[g]=1 only for the granted g; every other req_ready=0.
  - req_ready is independent of the requester's own valid except through grant selection; no combinational path from fpu_rsp_*.
- **On grant (req_valid[g] && req_ready[g]):**
  - Register load: fpu_req_valid=1, fpu_req_data=req_data[g], fpu_req_tag=free_tag.
  - Table update: busy[free_tag]=1, owner[free_tag]=g.
  - rr_ptr=(g+1) mod NUM_REQS.
- **No grant:**
  - If fpu_req_ready is high, fpu_req_valid clears.
  - rr_ptr holds.
- **Latency:** accept at cycle N → fpu_req_valid at N+1. Sustains 1 op/cycle while FPU ready and tags free.
- **Response path** (combinational, zero latency):
  - o = owner[fpu_rsp_tag].
  - rsp_valid[o] = fpu_rsp_valid && busy[fpu_rsp_tag]; all other rsp_valid=0.
  - rsp_data = fpu_rsp_data.
  - fpu_rsp_ready = rsp_ready[o] when busy[fpu_rsp_tag], else 1 (stale tag dropped).
- **Response handshake** (fpu_rsp_valid && fpu_rsp_ready && busy): busy[fpu_rsp_tag]=0 next cycle.
- **pending_count:**
  - +1 on grant, −1 on busy-response retire.
  - Both in the same cycle → unchanged; also the free tag is reused only from the next cycle on.
- **Full:** pending_count==MAX_PENDING → all req_ready=0, and the output register still drains. A response retiring in cycle N enables a grant at N+1, not N.
- **Stale response** (tag not busy) is consumed and dropped. Simulation assertion fires unless the response arrives within the post-reset window.
- **Reset mid-operation:**
  - Discards the registered request and all pending entries.
  - Responses arriving after reset are stale and dropped.

Test Plan:
1. All 4 requesters valid continuously, FPU always ready → grants 0,1,2,3,0,...; fpu_req_tag 0,1,2,...; no grant after 8 unretired ops; pending_count=8.
2. Only requester 2 valid, FPU ready, responses returned 3 cycles later → req_ready[2] asserted every cycle until pending full.
3. FPU stalls (fpu_req_ready=0) for 5 cycles with requester 1 valid → one op held stable in output register, req_ready all 0 during stall; op completes the cycle after ready returns.
4. Ops tags 0(req 3), 1(req 0) outstanding; responses tag 1 then tag 0 with rsp_ready=1 → rsp_valid[0] then rsp_valid[3] with matching data; pending_count 2→1→0.
5. pending=8, response on tag 5 same cycle a request waits → no grant that cycle; next cycle grant with fpu_req_tag=5.
6. reset asserted with 4 pending and fpu_req_valid=1 → next cycle fpu_req_valid=0, pending_count=0; subsequent fpu_rsp_tag=2 response dropped, all rsp_valid=0, fpu_rsp_ready=1.
